// File: rtl/starfield_ctrl.sv
// starfield_ctrl: register front-end and motion sequencer for the starfield.
// Keeps shadow copies of the starfield registers and writes them through the
// starfield's single write port. A CPU write always takes the port first.
// In auto mode it moves speed and direction one step toward the CPU-set
// targets once every (rate+1) unpaused frames.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   vblank, pause     frame level (a rising edge is one frame) and ramp freeze
//   cpu_addr/data/write  CPU register write; cpu_rdata is the registered readback
//   sf_addr/data/write   starfield register write port (single-cycle pulse)
//   busy, ramp_done   init or pending flush / current values equal the targets
module starfield_ctrl #(
  parameter int RATE_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic       pause,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_data,
  input  logic       cpu_write,
  output logic [7:0] cpu_rdata,
  output logic [2:0] sf_addr,
  output logic [7:0] sf_data,
  output logic       sf_write,
  output logic       busy,
  output logic       ramp_done
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [2:0]        init_idx;   // 0..4 = next address to write, 5 = done
  logic              enable, hdir, vdir, tgt_hdir, tgt_vdir, auto_en;
  logic [7:0]        hspd, vspd, tgt_hspd, tgt_vspd;
  logic [RATE_W-1:0] rate, frame_cnt;
  logic              vb_q;
  logic [3:0]        dirty;      // bit i = starfield field i+1 (hdir, hspd, vdir, vspd)

  // One step toward the target: shed speed before reversing direction.
  function automatic logic [8:0] step_axis(input logic dir, input logic [7:0] spd,
                                           input logic tdir, input logic [7:0] tspd);
    if (dir != tdir)  return (spd == 8'd0) ? {~dir, spd} : {dir, spd - 8'd1};
    else if (spd < tspd) return {dir, spd + 8'd1};
    else if (spd > tspd) return {dir, spd - 8'd1};
    else return {dir, spd};
  endfunction

  logic       tick, do_step, cpu_pt, flush, init_wr;
  logic [8:0] h_nx, v_nx;
  logic [3:0] step_chg, dirty_nx;
  logic [2:0] flush_addr, wr_addr;
  logic [7:0] wr_data, rd_nx;
  logic [7:0] fval [5];

  always_comb begin
    fval[0] = {7'd0, enable};
    fval[1] = {7'd0, hdir};
    fval[2] = hspd;
    fval[3] = {7'd0, vdir};
    fval[4] = vspd;

    tick    = vblank && !vb_q && auto_en && !pause;
    // A step is dropped (not deferred) while an earlier step is still flushing.
    do_step = tick && (frame_cnt == rate) && (dirty == 4'd0);
    h_nx    = step_axis(hdir, hspd, tgt_hdir, tgt_hspd);
    v_nx    = step_axis(vdir, vspd, tgt_vdir, tgt_vspd);
    step_chg = 4'd0;
    if (do_step)
      step_chg = {v_nx[7:0] != vspd, v_nx[8] != vdir, h_nx[7:0] != hspd, h_nx[8] != hdir};

    cpu_pt  = cpu_write && (cpu_addr <= 4'd4);
    init_wr = (state == S_INIT) && (init_idx <= 3'd4) && !cpu_pt;
    flush   = (state == S_RUN) && (dirty != 4'd0) && !cpu_pt;

    flush_addr = 3'd4;
    if (dirty[0])      flush_addr = 3'd1;
    else if (dirty[1]) flush_addr = 3'd2;
    else if (dirty[2]) flush_addr = 3'd3;

    wr_addr = 3'd0;
    wr_data = 8'd0;
    if (cpu_pt) begin
      wr_addr = cpu_addr[2:0];
      wr_data = (cpu_addr == 4'd2 || cpu_addr == 4'd4) ? cpu_data : {7'd0, cpu_data[0]};
    end else if (init_wr) begin
      wr_addr = init_idx;
      wr_data = fval[init_idx];
    end else if (flush) begin
      wr_addr = flush_addr;
      wr_data = fval[flush_addr];
    end

    // Step sets, flush issue clears, and a CPU write to the same field wins last.
    dirty_nx = dirty | step_chg;
    if (flush) dirty_nx[flush_addr - 3'd1] = 1'b0;
    if (cpu_pt && cpu_addr != 4'd0) dirty_nx[cpu_addr[1:0] - 2'd1] = 1'b0;

    case (cpu_addr)
      4'd0:    rd_nx = {7'd0, enable};
      4'd1:    rd_nx = {7'd0, hdir};
      4'd2:    rd_nx = hspd;
      4'd3:    rd_nx = {7'd0, vdir};
      4'd4:    rd_nx = vspd;
      4'd5:    rd_nx = {7'd0, tgt_hdir};
      4'd6:    rd_nx = tgt_hspd;
      4'd7:    rd_nx = {7'd0, tgt_vdir};
      4'd8:    rd_nx = tgt_vspd;
      4'd9:    rd_nx = 8'(rate);
      4'd10:   rd_nx = {7'd0, auto_en};
      4'd11:   rd_nx = {6'd0, ramp_done, busy};
      default: rd_nx = 8'd0;
    endcase
  end

  assign busy      = (state == S_INIT) || (dirty != 4'd0);
  assign ramp_done = (hdir == tgt_hdir) && (hspd == tgt_hspd) &&
                     (vdir == tgt_vdir) && (vspd == tgt_vspd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      init_idx <= 3'd0;
      {enable, hdir, vdir, tgt_hdir, tgt_vdir, auto_en} <= 6'd0;
      {hspd, vspd, tgt_hspd, tgt_vspd} <= 32'd0;
      rate <= '0;
      frame_cnt <= '0;
      vb_q <= 1'b0;
      dirty <= 4'd0;
      sf_write <= 1'b0;
      sf_addr <= 3'd0;
      sf_data <= 8'd0;
      cpu_rdata <= 8'd0;
    end else begin
      vb_q      <= vblank;
      cpu_rdata <= rd_nx;
      dirty     <= dirty_nx;
      sf_write  <= cpu_pt || init_wr || flush;
      if (cpu_pt || init_wr || flush) begin
        sf_addr <= wr_addr;
        sf_data <= wr_data;
      end
      // Hold one extra cycle after the last init write so busy drops after it.
      if (state == S_INIT && !cpu_pt) begin
        if (init_idx == 3'd5) state <= S_RUN;
        else init_idx <= init_idx + 3'd1;
      end
      if (tick) frame_cnt <= (frame_cnt == rate) ? '0 : frame_cnt + 1'b1;
      if (do_step) begin
        {hdir, hspd} <= h_nx;
        {vdir, vspd} <= v_nx;
      end
      if (cpu_write) begin
        case (cpu_addr)
          4'd0:  enable   <= cpu_data[0];
          4'd1:  hdir     <= cpu_data[0];
          4'd2:  hspd     <= cpu_data;
          4'd3:  vdir     <= cpu_data[0];
          4'd4:  vspd     <= cpu_data;
          4'd5:  tgt_hdir <= cpu_data[0];
          4'd6:  tgt_hspd <= cpu_data;
          4'd7:  tgt_vdir <= cpu_data[0];
          4'd8:  tgt_vspd <= cpu_data;
          4'd9:  rate     <= RATE_W'(cpu_data);
          4'd10: auto_en  <= cpu_data[0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_starfield_ctrl.sv
module tb_starfield_ctrl;
  logic       clk = 0, rst = 1, vblank = 0, pause = 0, cpu_write = 0;
  logic [3:0] cpu_addr = 0;
  logic [7:0] cpu_data = 0;
  logic [7:0] cpu_rdata, sf_data;
  logic [2:0] sf_addr;
  logic       sf_write, busy, ramp_done;
  int total = 0, bad = 0;

  starfield_ctrl #(.RATE_W(8)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .pause(pause),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .sf_addr(sf_addr), .sf_data(sf_data),
    .sf_write(sf_write), .busy(busy), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string name, input logic [2:0] a, input logic [7:0] d);
    chk({name, ".wr"}, sf_write, 1);
    chk({name, ".addr"}, sf_addr, a);
    chk({name, ".data"}, sf_data, d);
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data = d; cpu_write = 1;
    tick();
    cpu_write = 0;
  endtask

  task automatic do_reset();
    rst = 1; vblank = 0; pause = 0; cpu_write = 0;
    tick(); tick();
    rst = 0;
    repeat (6) tick();
  endtask

  // One frame: vblank edge, then the flush cycle, then an idle cycle.
  task automatic frame(input string name, input logic p, input logic exp_wr,
                       input logic [2:0] a, input logic [7:0] d);
    pause = p; vblank = 1;
    tick();
    vblank = 0; pause = 0;
    tick();
    if (exp_wr) chk_wr(name, a, d);
    else chk({name, ".nowr"}, sf_write, 0);
    tick();
    chk({name, ".single"}, sf_write, 0);
  endtask

  typedef struct {
    logic [3:0] addr; logic [7:0] data; logic wr;
    logic exp_w; logic [2:0] exp_a; logic [7:0] exp_d; logic [7:0] exp_rd;
  } vec_t;

  vec_t vt [15];

  initial begin
    vt[0]  = '{4'd2,  8'h10, 1, 1, 3'd2, 8'h10, 8'h00};
    vt[1]  = '{4'd2,  8'h00, 0, 0, 3'd0, 8'h00, 8'h10};
    vt[2]  = '{4'd9,  8'h07, 1, 0, 3'd0, 8'h00, 8'h00};
    vt[3]  = '{4'd9,  8'h00, 0, 0, 3'd0, 8'h00, 8'h07};
    vt[4]  = '{4'd15, 8'hAA, 1, 0, 3'd0, 8'h00, 8'h00};
    vt[5]  = '{4'd15, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00};
    vt[6]  = '{4'd0,  8'hFF, 1, 1, 3'd0, 8'h01, 8'h00};
    vt[7]  = '{4'd0,  8'h00, 0, 0, 3'd0, 8'h00, 8'h01};
    vt[8]  = '{4'd1,  8'h03, 1, 1, 3'd1, 8'h01, 8'h00};
    vt[9]  = '{4'd11, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00};
    vt[10] = '{4'd5,  8'h01, 1, 0, 3'd0, 8'h00, 8'h00};
    vt[11] = '{4'd6,  8'h10, 1, 0, 3'd0, 8'h00, 8'h00};
    vt[12] = '{4'd11, 8'h00, 0, 0, 3'd0, 8'h00, 8'h02};
    vt[13] = '{4'd5,  8'h00, 0, 0, 3'd0, 8'h00, 8'h01};
    vt[14] = '{4'd1,  8'h00, 0, 0, 3'd0, 8'h00, 8'h01};

    // Reset state.
    tick(); tick();
    chk("rst.sf_write", sf_write, 0);
    chk("rst.sf_addr", sf_addr, 0);
    chk("rst.sf_data", sf_data, 0);
    chk("rst.rdata", cpu_rdata, 0);
    chk("rst.busy", busy, 1);
    chk("rst.ramp_done", ramp_done, 1);

    // Init sequence after release.
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_wr($sformatf("init%0d", i), 3'(i), 8'h00);
      chk($sformatf("init%0d.busy", i), busy, 1);
    end
    tick();
    chk("init.end.wr", sf_write, 0);
    chk("init.end.busy", busy, 0);

    // Reset mid-init restarts at address 0.
    rst = 1; tick(); rst = 0;
    tick(); tick();
    rst = 1; tick();
    chk("midinit.rst.wr", sf_write, 0);
    rst = 0; tick();
    chk_wr("midinit.restart", 3'd0, 8'h00);
    repeat (5) tick();
    chk("midinit.busy", busy, 0);

    // Register map vectors.
    for (int i = 0; i < 15; i++) begin
      cpu_addr = vt[i].addr; cpu_data = vt[i].data; cpu_write = vt[i].wr;
      tick();
      cpu_write = 0;
      chk($sformatf("vec%0d.wr", i), sf_write, vt[i].exp_w);
      if (vt[i].exp_w) begin
        chk($sformatf("vec%0d.addr", i), sf_addr, vt[i].exp_a);
        chk($sformatf("vec%0d.data", i), sf_data, vt[i].exp_d);
      end
      chk($sformatf("vec%0d.rdata", i), cpu_rdata, vt[i].exp_rd);
    end

    // Ramp: hspd 3 down to 0, flip hdir, then up to 2.
    do_reset();
    cpu_wr(4'd2, 8'd3); cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd5, 8'd1); cpu_wr(4'd6, 8'd2);
    cpu_wr(4'd9, 8'd0); cpu_wr(4'd10, 8'd1);
    tick();
    begin
      logic [2:0] ra [6];
      logic [7:0] rd [6];
      ra = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2};
      rd = '{8'd2, 8'd1, 8'd0, 8'd1, 8'd1, 8'd2};
      for (int i = 0; i < 6; i++) begin
        frame($sformatf("ramp%0d", i), 0, 1, ra[i], rd[i]);
        chk($sformatf("ramp%0d.done", i), ramp_done, (i == 5));
      end
    end

    // Rate 2 with pause: steps on every 3rd unpaused frame.
    cpu_wr(4'd6, 8'h20); cpu_wr(4'd9, 8'd2);
    begin
      logic [8:0] pp;
      logic [8:0] sw;
      logic [7:0] exp_spd;
      pp = 9'b000001110;   // bit i = pause during frame i
      sw = 9'b100100000;   // bit i = step expected on frame i
      exp_spd = 8'd2;
      for (int i = 0; i < 9; i++) begin
        if (sw[i]) exp_spd = exp_spd + 8'd1;
        frame($sformatf("rate%0d", i), pp[i], sw[i], 3'd2, exp_spd);
      end
    end

    // Step dirties hspd and vspd while the CPU writes vspd in the same cycle.
    do_reset();
    cpu_wr(4'd6, 8'd5); cpu_wr(4'd8, 8'd5); cpu_wr(4'd10, 8'd1);
    vblank = 1; cpu_addr = 4'd4; cpu_data = 8'h55; cpu_write = 1;
    tick();
    vblank = 0; cpu_write = 0;
    chk_wr("coll.cpu", 3'd4, 8'h55);
    tick();
    chk_wr("coll.flush", 3'd2, 8'd1);
    tick();
    chk("coll.single", sf_write, 0);
    chk("coll.busy", busy, 0);
    cpu_addr = 4'd4; tick();
    chk("coll.vspd", cpu_rdata, 8'h55);
    cpu_addr = 4'd2; tick();
    chk("coll.hspd", cpu_rdata, 8'd1);

    // CPU write lands on the cycle the flush would go out.
    do_reset();
    cpu_wr(4'd6, 8'd1); cpu_wr(4'd10, 8'd1);
    vblank = 1;
    tick();
    vblank = 0;
    chk("defer.busy", busy, 1);
    cpu_addr = 4'd1; cpu_data = 8'd1; cpu_write = 1;
    tick();
    cpu_write = 0;
    chk_wr("defer.cpu", 3'd1, 8'd1);
    tick();
    chk_wr("defer.flush", 3'd2, 8'd1);
    tick();
    chk("defer.single", sf_write, 0);
    chk("defer.busy2", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/starfield_ctrl.md
Name: starfield_ctrl

Overview:
Register front-end and motion sequencer for the starfield generator. Holds shadow copies of the starfield registers and arbitrates CPU writes against its own writes onto the starfield's single write port. When auto mode is enabled, it ramps horizontal and vertical speed and direction toward CPU-set targets, one step per N frames. It sits between the CPU bus decode and the starfield instance.

Parameters:
RATE_W, 8, width of the frame-divider register and counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
vblank  in  1  vertical blank level; rising edge marks a frame
pause  in  1  freezes the ramp frame counter
cpu_addr  in  4  CPU register address
cpu_data  in  8  CPU write data
cpu_write  in  1  CPU write strobe, single cycle
cpu_rdata  out  8  registered readback of cpu_addr
sf_addr  out  3  starfield register address
sf_data  out  8  starfield write data
sf_write  out  1  starfield write strobe
busy  out  1  init or dirty writes pending
ramp_done  out  1  current values equal targets on both axes

Behaviour:
- Register map (writes):
  - 0 enable[0]; 1 hdir[0]; 2 hspd; 3 vdir[0]; 4 vspd.
  - 5 tgt_hdir[0]; 6 tgt_hspd; 7 tgt_vdir[0]; 8 tgt_vspd.
  - 9 rate; 10 ctrl (bit0 = auto).
  - 11 status, read-only: bit0 busy, bit1 ramp_done.
  - 12-15: writes ignored, read 0.
- Reset: all shadows, targets, rate, ctrl and frame_cnt = 0. sf_write = 0, sf_addr = 0, sf_data = 0, cpu_rdata = 0. FSM enters INIT.
- INIT: writes addresses 0..4 with shadow values (all 0), one per cycle, then goes to RUN. busy = 1 throughout INIT. A rst asserted mid-INIT restarts INIT at address 0.
- Passthrough: a CPU write to 0-4 updates the shadow and drives sf_addr/sf_data/sf_write = 1 on the next cycle (latency 1). CPU always has priority.
- Frame tick: vblank is registered; a rising edge with auto = 1 and pause = 0 is a tick.
  - On a tick, if frame_cnt == rate: frame_cnt <= 0 and a step is taken. Otherwise frame_cnt increments.
  - rate = 0 steps every frame. While pause = 1 or auto = 0, frame_cnt holds.
- Step (same rule per axis, both axes in the same cycle):
  - If dir != tgt_dir: when spd == 0, flip dir; otherwise spd - 1.
  - Else if spd < tgt_spd: spd + 1. Else if spd > tgt_spd: spd - 1. Else no change.
  - Each changed field sets its dirty flag. The shadow updates immediately.
- If a step would occur while any dirty flag is still set, the step is dropped; frame_cnt still resets.
- Dirty flush (RUN): the lowest-address dirty field (1, 2, 3, 4) is written once per cycle on cycles with no CPU passthrough pending. Its flag clears when it is issued.
- Collision: a CPU write to field f in the same cycle as, or after, a step sets dirty[f]. The CPU value wins: the shadow takes the CPU value, dirty[f] clears, and no sequencer write of f occurs.
- sf_write is a single-cycle pulse. There is never more than one starfield write per cycle.
- busy = INIT or any dirty flag set.
- ramp_done = (hdir == tgt_hdir && hspd == tgt_hspd && vdir == tgt_vdir && vspd == tgt_vspd). It is combinational from registers.
- cpu_rdata is loaded every cycle from the map indexed by cpu_addr. Unused bits read 0.
- All arithmetic is 8-bit unsigned. Speeds never wrap, because a step moves by exactly 1 toward the target.

Test Plan:
- Reset release -> sf_write high for 5 consecutive cycles, addr 0,1,2,3,4, data 0; busy falls the cycle after the last write.
- CPU write addr 2 data 0x10 -> next cycle sf_addr = 2, sf_data = 0x10, sf_write = 1; readback addr 2 = 0x10.
- Setup: auto = 1, rate = 0, hspd = 3, hdir = 0, tgt_hdir = 1, tgt_hspd = 2. Apply 6 vblank edges -> hspd sequence 2,1,0, then hdir flips to 1, then hspd 1,2. ramp_done rises after the 6th step, and each step produces exactly the changed-field writes.
- Setup: rate = 2, pause toggled high for 3 frames -> steps occur only on every 3rd unpaused frame.
- Step dirties fields 2 and 4, and the CPU writes addr 4 data 0x55 in the same cycle -> only addr 2 is written by the sequencer; vspd shadow and starfield receive 0x55.
- Setup: CPU write to addr 1 in the same cycle the sequencer would flush -> the CPU write is issued first and the sequencer write is delayed one cycle; no lost writes.
